c499_sec_encoder_obf: RTL and testbench

- Streaming single-error-correcting check-bit generator: the encoder matching the c499 SEC corrector.
- Each 32-bit data word produces the 8 check bits r[7:0] that make the corrector's syndrome zero.
- Two-stage valid/ready pipeline; sits upstream of storage/link that the corrector reads.
- Two check bits pass through key-gated obfuscation cells (same 2-bit key code as the corrector's obfuscated nets); key loaded serially.

---
 rtl/c499_sec_encoder_obf.sv | 157 +++++++++++++++
 tb/tb_c499_sec_encoder_obf.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c499_sec_encoder_obf.sv
// c499_sec_encoder_obf: two-stage valid/ready SEC check-bit generator.
// Stage 1 captures the data word plus its nibble and stride-4 parities;
// stage 2 folds them into r[7:0], applies chk_en gating and the key cells.
module c499_sec_encoder_obf #(
    parameter logic [3:0]  KEY_RST = 4'b0000,
    parameter int unsigned OBF_A   = 3,
    parameter int unsigned OBF_B   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_chk_en,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [7:0]  out_check,
    input  logic        key_shift,
    input  logic        key_bit,
    output logic [3:0]  key_q
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 8;
    localparam int unsigned KW = 4;
    localparam int unsigned NP = 8;

    // Obfuscation cell: 00 pass, 10 invert, 01 force 1, 11 force 0.
    function automatic logic key_cell(input logic v, input logic [1:0] k);
        logic o;
        case (k)
            2'b00:   o = v;
            2'b10:   o = ~v;
            2'b01:   o = 1'b1;
            default: o = 1'b0;
        endcase
        return o;
    endfunction

    logic          s1_full_q, s1_full_d;
    logic [DW-1:0] s1_data_q, s1_data_d;
    logic          s1_en_q,   s1_en_d;
    logic [NP-1:0] s1_nib_q,  s1_nib_d;
    logic [NP-1:0] s1_str_q,  s1_str_d;
    logic          s2_full_q, s2_full_d;
    logic [DW-1:0] s2_data_q, s2_data_d;
    logic [CW-1:0] s2_check_q, s2_check_d;
    logic [KW-1:0] key_d;

    logic [NP-1:0] nib_c;
    logic [NP-1:0] str_c;
    logic [CW-1:0] raw_c;
    logic [CW-1:0] check_c;
    logic          s2_can_take_c;
    logic          s1_move_c;
    logic          accept_c;

    assign s2_can_take_c = !s2_full_q || out_ready;
    assign in_ready      = !s1_full_q || s2_can_take_c;
    assign s1_move_c     = s1_full_q && s2_can_take_c;
    assign accept_c      = in_valid && in_ready;

    assign out_valid = s2_full_q;
    assign out_data  = s2_data_q;
    assign out_check = s2_check_q;

    // Stage-1 parities: nibble k = d[4k+3:4k]; stride j = every 4th bit of a half-word.
    always_comb begin
        nib_c = '0;
        str_c = '0;
        for (int k = 0; k < 8; k++) begin
            nib_c[k] = ^in_data[4*k +: 4];
        end
        for (int j = 0; j < 4; j++) begin
            str_c[j]   = in_data[j]      ^ in_data[j+4]  ^ in_data[j+8]  ^ in_data[j+12];
            str_c[4+j] = in_data[16+j]   ^ in_data[20+j] ^ in_data[24+j] ^ in_data[28+j];
        end
    end

    // Stage-2 check bits from stored parities, then gating and key cells.
    always_comb begin
        raw_c    = '0;
        raw_c[0] = s1_str_q[0] ^ s1_nib_q[4] ^ s1_nib_q[5];
        raw_c[1] = s1_str_q[1] ^ s1_nib_q[6] ^ s1_nib_q[7];
        raw_c[2] = s1_str_q[2] ^ s1_nib_q[4] ^ s1_nib_q[6];
        raw_c[3] = s1_str_q[3] ^ s1_nib_q[5] ^ s1_nib_q[7];
        raw_c[4] = s1_str_q[4] ^ s1_nib_q[0] ^ s1_nib_q[1];
        raw_c[5] = s1_str_q[5] ^ s1_nib_q[2] ^ s1_nib_q[3];
        raw_c[6] = s1_str_q[6] ^ s1_nib_q[0] ^ s1_nib_q[2];
        raw_c[7] = s1_str_q[7] ^ s1_nib_q[1] ^ s1_nib_q[3];
        check_c  = s1_en_q ? raw_c : '0;
        check_c[3'(OBF_A)] = key_cell(check_c[3'(OBF_A)], key_q[1:0]);
        check_c[3'(OBF_B)] = key_cell(check_c[3'(OBF_B)], key_q[3:2]);
    end

    // Next-state for both pipeline stages and the serial key register.
    always_comb begin
        s1_full_d  = s1_full_q;
        s1_data_d  = s1_data_q;
        s1_en_d    = s1_en_q;
        s1_nib_d   = s1_nib_q;
        s1_str_d   = s1_str_q;
        s2_full_d  = s2_full_q;
        s2_data_d  = s2_data_q;
        s2_check_d = s2_check_q;
        key_d      = key_q;

        if (accept_c) begin
            s1_full_d = 1'b1;
            s1_data_d = in_data;
            s1_en_d   = in_chk_en;
            s1_nib_d  = nib_c;
            s1_str_d  = str_c;
        end else if (s1_move_c) begin
            s1_full_d = 1'b0;
        end

        if (s1_move_c) begin
            s2_full_d  = 1'b1;
            s2_data_d  = s1_data_q;
            s2_check_d = check_c;
        end else if (out_ready) begin
            s2_full_d = 1'b0;
        end

        if (key_shift) begin
            key_d = {key_q[2:0], key_bit};
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_full_q  <= 1'b0;
            s1_data_q  <= '0;
            s1_en_q    <= 1'b0;
            s1_nib_q   <= '0;
            s1_str_q   <= '0;
            s2_full_q  <= 1'b0;
            s2_data_q  <= '0;
            s2_check_q <= '0;
            key_q      <= KEY_RST;
        end else begin
            s1_full_q  <= s1_full_d;
            s1_data_q  <= s1_data_d;
            s1_en_q    <= s1_en_d;
            s1_nib_q   <= s1_nib_d;
            s1_str_q   <= s1_str_d;
            s2_full_q  <= s2_full_d;
            s2_data_q  <= s2_data_d;
            s2_check_q <= s2_check_d;
            key_q      <= key_d;
        end
    end

endmodule

// File: tb/tb_c499_sec_encoder_obf.sv
// Bench for c499_sec_encoder_obf: directed literal cases plus a randomized
// stream checked against a queue-based scoreboard and a corrector model.
module tb_c499_sec_encoder_obf;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_chk_en;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_check;
    logic        key_shift;
    logic        key_bit;
    logic [3:0]  key_q;

    c499_sec_encoder_obf dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_chk_en (in_chk_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_check (out_check),
        .key_shift (key_shift),
        .key_bit   (key_bit),
        .key_q     (key_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic        en;
    } word_t;

    word_t      q[$];
    logic [3:0] key_m    = 4'b0000;
    logic [3:0] key_prev = 4'b0000;
    logic [3:0] head_key = 4'b0000;
    bit         bound    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-membership masks written straight from the check-equation lists.
    function automatic logic [31:0] eq_mask(input int i);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 32; b++) begin
            case (i)
                0: m[b] = (b < 16 && b % 4 == 0) || (b >= 16 && b <= 23);
                1: m[b] = (b < 16 && b % 4 == 1) || (b >= 24);
                2: m[b] = (b < 16 && b % 4 == 2) || (b >= 16 && b <= 19) || (b >= 24 && b <= 27);
                3: m[b] = (b < 16 && b % 4 == 3) || (b >= 20 && b <= 23) || (b >= 28);
                4: m[b] = (b >= 16 && b % 4 == 0) || (b <= 7);
                5: m[b] = (b >= 16 && b % 4 == 1) || (b >= 8 && b <= 15);
                6: m[b] = (b >= 16 && b % 4 == 2) || (b <= 3) || (b >= 8 && b <= 11);
                default: m[b] = (b >= 16 && b % 4 == 3) || (b >= 4 && b <= 7) || (b >= 12 && b <= 15);
            endcase
        end
        return m;
    endfunction

    function automatic logic [7:0] raw_check(input logic [31:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = ^(d & eq_mask(i));
        return r;
    endfunction

    function automatic logic apply_key(input logic v, input logic [1:0] k);
        if (k == 2'b00) return v;
        if (k == 2'b10) return ~v;
        if (k == 2'b01) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] model_check(input logic [31:0] d, input logic en, input logic [3:0] k);
        logic [7:0] r;
        r    = en ? raw_check(d) : 8'h00;
        r[3] = apply_key(r[3], k[1:0]);
        r[6] = apply_key(r[6], k[3:2]);
        return r;
    endfunction

    // Scoreboard: observe at negedge, then apply the coming edge to the model.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("key_q", 32'(key_q), 32'(key_m));
            chk("in_ready", 32'(in_ready), 32'(!(q.size() >= 2 && !out_ready)));
            if (q.size() == 0) chk("out_valid_empty", 32'(out_valid), 32'd0);
            if (q.size() >= 2) chk("out_valid_full", 32'(out_valid), 32'd1);
            if (out_valid && q.size() > 0) begin
                if (!bound) begin
                    head_key = key_prev;
                    bound    = 1'b1;
                end
                chk("out_data", out_data, q[0].data);
                chk("out_check", 32'(out_check), 32'(model_check(q[0].data, q[0].en, head_key)));
            end
        end
        if (rst) begin
            q.delete();
            key_m    = 4'b0000;
            key_prev = 4'b0000;
            bound    = 1'b0;
        end else begin
            if (out_valid && out_ready && q.size() > 0) begin
                if (mon_en && head_key == 4'b0000 && q[0].en) begin
                    logic [31:0] flipped;
                    logic [31:0] fixed;
                    logic [7:0]  syn;
                    int          j;
                    chk("syndrome_zero", 32'(raw_check(out_data) ^ out_check), 32'd0);
                    j       = int'($urandom_range(31, 0));
                    flipped = out_data ^ (32'd1 << j);
                    syn     = raw_check(flipped) ^ out_check;
                    fixed   = flipped;
                    for (int b = 0; b < 32; b++)
                        if (raw_check(32'd1 << b) == syn) fixed = flipped ^ (32'd1 << b);
                    chk("corrected", fixed, q[0].data);
                end
                void'(q.pop_front());
                bound = 1'b0;
            end
            if (in_valid && in_ready) q.push_back('{data: in_data, en: in_chk_en});
            key_prev = key_m;
            if (key_shift) key_m = {key_m[2:0], key_bit};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [3:0] k);
        for (int i = 3; i >= 0; i--) begin
            key_shift = 1'b1;
            key_bit   = k[i];
            tick();
        end
        key_shift = 1'b0;
        key_bit   = 1'b0;
    endtask

    // Sends one word into an empty pipeline and checks latency and check bits.
    task automatic send_word(input logic [31:0] d, input logic en, input logic [7:0] exp, input string name);
        int lat;
        in_valid  = 1'b1;
        in_data   = d;
        in_chk_en = en;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 8) begin
            tick();
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'd2);
        chk(name, 32'(out_check), 32'(exp));
        tick();
    endtask

    initial begin
        logic [31:0] sw[3];
        int          idx;
        int          accepted;
        int          cycles;
        bit          pending;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_chk_en = 1'b1;
        out_ready = 1'b1; key_shift = 1'b0; key_bit = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_key", 32'(key_q), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_check", 32'(out_check), 32'd0);
        mon_en = 1'b1;

        send_word(32'h0000_0001, 1'b1, 8'h51, "d1");
        send_word(32'h8000_0000, 1'b1, 8'h8A, "d31");
        send_word(32'hFFFF_FFFF, 1'b1, 8'h00, "ones");
        send_word(32'h0000_0000, 1'b1, 8'h00, "zero");
        load_key(4'b0011);
        chk("key_shift_order", 32'(key_q), 32'h3);
        send_word(32'h0000_0008, 1'b1, 8'h50, "key0011");
        load_key(4'b1100);
        send_word(32'h0000_0001, 1'b1, 8'h11, "key1100");
        load_key(4'b0010);
        send_word(32'h0000_0001, 1'b1, 8'h59, "key0010");
        load_key(4'b0000);
        send_word(32'hDEAD_BEEF, 1'b0, 8'h00, "gate_k0");
        load_key(4'b0100);
        send_word(32'hDEAD_BEEF, 1'b0, 8'h40, "gate_k4");
        load_key(4'b0000);

        // Back-pressure: three words against a stalled output.
        sw[0] = 32'h1111_1111; sw[1] = 32'h2222_2222; sw[2] = 32'h0000_0001;
        in_chk_en = 1'b1;
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (idx < 3);
            if (idx < 3) in_data = sw[idx];
            #0;
            if (in_valid && in_ready) idx++;
            tick();
        end
        chk("stall_accepts", 32'(idx), 32'd2);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        cycles = 0;
        while (idx < 3 && cycles < 10) begin
            in_valid = 1'b1;
            in_data  = sw[idx];
            #0;
            if (in_ready) idx++;
            tick();
            cycles++;
        end
        in_valid = 1'b0;
        chk("stall_release", 32'(idx), 32'd3);
        repeat (4) tick();

        // Reset with both stages full and key 1111; reset wins over shift/valid.
        load_key(4'b1111);
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = 32'hCAFE_0000 + 32'(c);
            #0;
            if (in_ready) idx++;
            tick();
        end
        chk("pre_rst_full", 32'(out_valid && !in_ready), 32'd1);
        rst = 1'b1; key_shift = 1'b1; key_bit = 1'b1; in_valid = 1'b1;
        tick();
        rst = 1'b0; key_shift = 1'b0; key_bit = 1'b0; in_valid = 1'b0;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_key", 32'(key_q), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        send_word(32'h0000_0001, 1'b1, 8'h51, "post_rst");

        // Randomized stream with random handshakes, gating and key shifts.
        accepted = 0;
        cycles   = 0;
        pending  = 1'b0;
        while (accepted < 10000 && cycles < 60000) begin
            if (!pending) begin
                in_valid  = ($urandom_range(3, 0) != 0);
                in_data   = $urandom;
                in_chk_en = ($urandom_range(7, 0) != 0);
            end
            out_ready = ($urandom_range(3, 0) != 0);
            key_shift = ($urandom_range(7, 0) == 0);
            key_bit   = 1'($urandom_range(1, 0));
            #0;
            pending = in_valid && !in_ready;
            if (in_valid && in_ready) accepted++;
            tick();
            cycles++;
        end
        chk("random_budget", 32'(accepted >= 10000), 32'd1);
        in_valid  = 1'b0;
        key_shift = 1'b0;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("drained", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
